// File: rtl/pcx_src_req_q_pkg.sv
// Shared types and constants for the PCX source request queue.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pcx_q_pkg;

    localparam int PCX_DEST_W = 5;
    localparam int PCX_PKT_W  = 124;

    // Destination bit positions within the request vector.
    localparam int DEST_L2B0 = 0;
    localparam int DEST_L2B1 = 1;
    localparam int DEST_L2B2 = 2;
    localparam int DEST_L2B3 = 3;
    localparam int DEST_FPIO = 4;

    // One queued request. Field order matches the packed FIFO word used by the top.
    typedef struct packed {
        logic [PCX_DEST_W-1:0] dest;
        logic                  atom;
        logic [PCX_PKT_W-1:0]  data;
    } pcx_entry_t;

    // True when more than one destination bit is set.
    function automatic logic multi_hot(input logic [PCX_DEST_W-1:0] v);
        return (v & (v - PCX_DEST_W'(1))) != '0;
    endfunction

endpackage

// File: rtl/pcx_src_req_q_if.sv
// Core-side and arbiter-side signals of one PCX source request port.
// Latency: n/a (wiring only).
// Backpressure: n/a; the core relies on credits, the arbiter pops only when vld.
interface pcx_src_req_q_if
    import pcx_q_pkg::*;
#(
    parameter int PKT_W = PCX_PKT_W
);
    logic [PCX_DEST_W-1:0] spc_pcx_req_pq;
    logic                  spc_pcx_atom_pq;
    logic [PKT_W-1:0]      spc_pcx_data_pa;
    logic [PCX_DEST_W-1:0] pcx_spc_grant_px;
    logic                  pcx_req_vld;
    logic [PCX_DEST_W-1:0] pcx_req_dest;
    logic                  pcx_req_atom;
    logic [PKT_W-1:0]      pcx_req_data;
    logic                  arb_pcx_pop;
    logic                  pcx_req_err;

    // Core plus arbiter view (drives requests and pops).
    modport master (
        output spc_pcx_req_pq, spc_pcx_atom_pq, spc_pcx_data_pa, arb_pcx_pop,
        input  pcx_spc_grant_px, pcx_req_vld, pcx_req_dest, pcx_req_atom,
               pcx_req_data, pcx_req_err
    );

    // Queue view.
    modport slave (
        input  spc_pcx_req_pq, spc_pcx_atom_pq, spc_pcx_data_pa, arb_pcx_pop,
        output pcx_spc_grant_px, pcx_req_vld, pcx_req_dest, pcx_req_atom,
               pcx_req_data, pcx_req_err
    );
endinterface

// File: rtl/pcx_src_req_q_fifo.sv
// Generic DEPTH x W FIFO with wrap-flag pointers, head shown combinationally.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module pcx_q_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           push_i,
    input  logic           pop_i,
    input  logic [W-1:0]   din_i,
    output logic           full_o,
    output logic           empty_o,
    output logic [PTR_W:0] cnt_o,
    output logic [W-1:0]   head_o
);
    logic [W-1:0]   mem_q [DEPTH];
    logic [PTR_W:0] wr_ptr_q;
    logic [PTR_W:0] rd_ptr_q;
    logic           do_push;
    logic           do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign cnt_o   = wr_ptr_q - rd_ptr_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

    // At full a same-cycle pop frees the slot being overwritten, so the push is kept.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    // Storage and pointer update.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[PTR_W-1:0]] <= din_i;
                wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
            end
        end
    end
endmodule

// File: rtl/pcx_src_req_q.sv
// Crossbar-side PCX request queue for one core: capture, FIFO, atomic gating, grant.
// Latency: req at N -> head at N+2; pop at N -> grant pulse at N+1.
// Backpressure: credit based (core keeps <= DEPTH outstanding); overflow pushes dropped.
// Optional checker enabled by defining PCX_SRC_REQ_CHK_EN (drives pcx_req_err).
module pcx_src_req_q
    import pcx_q_pkg::*;
#(
    parameter int PKT_W = PCX_PKT_W,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic rclk,
    input  logic reset,
    pcx_src_req_q_if.slave bus
);
    localparam int ENT_W = PCX_DEST_W + 1 + PKT_W;

    logic [PCX_DEST_W-1:0] req_pa_q;
    logic                  atom_pa_q;
    logic [PCX_DEST_W-1:0] grant_q;
    logic [PCX_DEST_W-1:0] grant_d;

    logic                  push;
    logic                  pop;
    logic                  vld;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [PTR_W:0]        fifo_cnt;
    logic [ENT_W-1:0]      wr_entry;
    logic [ENT_W-1:0]      head;
    logic [PCX_DEST_W-1:0] head_dest;
    logic                  head_atom;
    logic [PKT_W-1:0]      head_data;

    // PQ -> PA capture; the atomic flag only means something alongside a request.
    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            req_pa_q  <= '0;
            atom_pa_q <= 1'b0;
        end else begin
            req_pa_q  <= bus.spc_pcx_req_pq;
            atom_pa_q <= bus.spc_pcx_atom_pq && (bus.spc_pcx_req_pq != '0);
        end
    end

    assign push     = (req_pa_q != '0);
    assign wr_entry = {req_pa_q, atom_pa_q, bus.spc_pcx_data_pa};

    pcx_q_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk_i   (rclk),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (wr_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .cnt_o   (fifo_cnt),
        .head_o  (head)
    );

    assign {head_dest, head_atom, head_data} = head;

    // An atomic head is held back until its partner is queued behind it, so the
    // arbiter can always take the pair on back-to-back cycles.
    assign vld = !fifo_empty && (!head_atom || (fifo_cnt >= (PTR_W+1)'(2)));
    assign pop = bus.arb_pcx_pop && vld;

    assign bus.pcx_req_vld  = vld;
    assign bus.pcx_req_dest = head_dest;
    assign bus.pcx_req_atom = head_atom;
    assign bus.pcx_req_data = head_data;

    // Grant pulse carries the destination of the entry just popped.
    always_comb begin
        grant_d = '0;
        if (pop) begin
            grant_d = head_dest;
        end
    end

    // Registered grant.
    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            grant_q <= '0;
        end else begin
            grant_q <= grant_d;
        end
    end

    assign bus.pcx_spc_grant_px = grant_q;

`ifdef PCX_SRC_REQ_CHK_EN
    logic                  err_q;
    logic                  err_d;
    logic                  atom_pend_q;
    logic [PCX_DEST_W-1:0] atom_dest_q;

    // Sticky protocol error: bad request vector, overflow, broken atomic pair, stray pop.
    always_comb begin
        err_d = err_q;
        if (multi_hot(bus.spc_pcx_req_pq)) begin
            err_d = 1'b1;
        end
        if (push && fifo_full && !pop) begin
            err_d = 1'b1;
        end
        if (atom_pend_q && ((bus.spc_pcx_req_pq != atom_dest_q) || bus.spc_pcx_atom_pq)) begin
            err_d = 1'b1;
        end
        if (bus.arb_pcx_pop && !vld) begin
            err_d = 1'b1;
        end
    end

    // Remember the first half of an atomic pair for one cycle, and hold the error.
    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            err_q       <= 1'b0;
            atom_pend_q <= 1'b0;
            atom_dest_q <= '0;
        end else begin
            err_q       <= err_d;
            atom_pend_q <= bus.spc_pcx_atom_pq && (bus.spc_pcx_req_pq != '0);
            atom_dest_q <= bus.spc_pcx_req_pq;
        end
    end

    assign bus.pcx_req_err = err_q;
`else
    assign bus.pcx_req_err = 1'b0;
`endif

endmodule

// File: doc/pcx_src_req_q.md
Name: pcx_src_req_q

Overview:
- Crossbar-side receiver for one SPARC core's PCX request port; the far end of the core-side repeater.
- Captures the core's PQ-stage request vector, atomic flag and PA-stage packet into a small FIFO.
- Presents the head entry to the PCX destination arbiter.
- On each arbiter pop, returns a one-cycle PX-stage grant pulse to the core on the destination's grant bit.

Parameters:
- PKT_W, 124 (`PCX_WIDTH): PCX packet width.
- DEPTH, 4: FIFO entries; power of two, >= 2.
- PTR_W, 2: log2(DEPTH).

Ports:
- rclk  in  1  core clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- spc_pcx_req_pq  in  5  one-hot destination request, PQ stage (bits 0-3 L2 banks, bit 4 FPU/IO).
- spc_pcx_atom_pq  in  1  with req: this and next request form an atomic pair.
- spc_pcx_data_pa  in  PKT_W  packet; valid the cycle after its req (PA stage).
- pcx_spc_grant_px  out  5  one-cycle grant pulse per destination.
- pcx_req_vld  out  1  head entry valid to arbiter.
- pcx_req_dest  out  5  head entry destination vector.
- pcx_req_atom  out  1  head is first half of an atomic pair.
- pcx_req_data  out  PKT_W  head packet.
- arb_pcx_pop  in  1  arbiter consumes head this cycle; legal only when pcx_req_vld is high.
- pcx_req_err  out  1  sticky protocol error (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (async, active-high) clears all state.
  - Outputs grant=0, vld=0, dest=0, atom=0, data=0, err=0.
  - FIFO empties; pointers go to 0; atomic tracking clears.
  - A request in flight at PQ or PA is dropped.
- Capture pipeline:
  - Cycle N: req != 0 registers req_pa and atom_pa.
  - Cycle N+1: entry {req_pa, atom_pa, spc_pcx_data_pa} is written at the end of the cycle.
  - Entry is visible at the head no earlier than N+2.
  - Back-to-back requests every cycle are sustained.
- FIFO:
  - wr_ptr/rd_ptr are PTR_W+1 bits with an MSB wrap flag.
  - full: pointers differ only in the MSB. empty: pointers equal.
  - Push and pop in the same cycle are allowed at any occupancy, including full; occupancy is unchanged.
- Credit:
  - The core guarantees outstanding requests <= DEPTH.
  - A push while full without a same-cycle pop is dropped and the FIFO is unchanged.
- Head outputs:
  - vld=1 when the FIFO is non-empty, except for an atomic head.
  - Atomic head (atom=1): vld stays 0 until the second entry of the pair is also in the FIFO.
  - The arbiter must pop an atomic pair on two consecutive cycles. vld stays 1 for the second entry, with atom=0.
  - dest, atom and data show the head entry whenever non-empty, and 0 when empty.
- Grant:
  - A pop in cycle N with head dest D drives pcx_spc_grant_px = D in cycle N+1 for exactly one cycle.
  - Grant is registered and is 0 otherwise.
  - Consecutive pops give consecutive pulses.
- Atomic second request: the core sends it the cycle after the first, to the same destination, with atom_pq=0.

Optional Feature:
- Macro PCX_SRC_REQ_CHK_EN.
- Defined: pcx_req_err sets, sticky until reset, on any of:
  - req not one-hot and non-zero;
  - push dropped on full;
  - the cycle after atom_pq, the second req differs from the first or atom_pq is reasserted;
  - arb_pcx_pop while vld=0 (the pop is ignored).
- Undefined:
  - pcx_req_err is tied 0.
  - A non-one-hot req is stored as is.
  - A pop while vld=0 is ignored.

Decomposition:
- Package pcx_q_pkg holds:
  - PCX_DEST_W=5;
  - entry struct {dest[4:0], atom, data[PKT_W-1:0]};
  - destination bit indices (L2 bank 0-3, FPU/IO=4).
- Natural sub-module: pcx_q_fifo, a generic DEPTH x entry FIFO with push, pop, full, empty and head.
- pcx_src_req_q wraps pcx_q_fifo with the capture stage, atomic gating, grant register and checks.

Test Plan:
- Single request: req=5'b00100 at cycle 0, data=0xA5.. at cycle 1 -> vld=1, dest=00100, data=0xA5.. at cycle 2; pop at cycle 2 -> grant=00100 at cycle 3 only.
- Fill and wrap:
  - 4 requests on cycles 0-3 to dests 1, 2, 4, 8 with no pop -> full; FIFO then holds exactly 4 entries.
  - Continuous pop with a push every cycle for 12 cycles -> data emerges in order across pointer wrap.
  - Grants follow each pop by one cycle.
- Simultaneous push/pop at full: a 5th request arrives while a pop occurs in the same cycle -> no drop; occupancy stays 4; err=0.
- Atomic pair:
  - req=10000 with atom at cycle 0, req=10000 at cycle 1 -> vld stays 0 at cycle 2, then vld=1 with atom=1 at cycle 3.
  - Pops at cycles 3 and 4 -> grant=10000 at cycles 4 and 5.
- Reset mid-operation: 3 entries queued plus a request at PA stage, then reset asserted asynchronously between edges -> all outputs 0 immediately; after release, FIFO empty and the PA request never appears.
- Checks (PCX_SRC_REQ_CHK_EN): req=00011 -> err=1 from the next cycle and stays 1; a 5th push with no pop when full -> err=1 and head content unchanged.
